// File: rtl/addsub_seq_pkg.sv
// Shared types and constants for the multi-byte add/subtract sequencer.
package addsub_seq_pkg;

    localparam int unsigned BYTE_W = 8;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/addsub_seq_if.sv
// Control-unit / ALU-lane bundle for addsub_seq. The master side issues
// operations and hosts the ALU lane; the slave side is the sequencer.
interface addsub_seq_if
    import addsub_seq_pkg::*;
#(
    parameter int unsigned NBYTES = 4
) ();

    localparam int unsigned W = BYTE_W * NBYTES;

    logic              START;
    logic              SUB;
    logic [W-1:0]      A;
    logic [W-1:0]      B;
    logic              CISEL;
    logic              BSEL;
    logic [BYTE_W-1:0] ALU_A;
    logic [BYTE_W-1:0] ALU_B;
    logic [BYTE_W-1:0] ALU_S;
    logic              ALU_CO;
    logic              BUSY;
    logic              DONE;
    logic [W-1:0]      RESULT;
    logic              COUT;
    logic              OVF;
    logic              ZERO;

    modport master (
        output START, SUB, A, B, ALU_S, ALU_CO,
        input  CISEL, BSEL, ALU_A, ALU_B, BUSY, DONE, RESULT, COUT, OVF, ZERO
    );

    modport slave (
        input  START, SUB, A, B, ALU_S, ALU_CO,
        output CISEL, BSEL, ALU_A, ALU_B, BUSY, DONE, RESULT, COUT, OVF, ZERO
    );

endinterface

// File: rtl/addsub_seq.sv
// Multi-byte add/subtract sequencer: streams operand bytes LSB-first through an
// external 8-bit ALU lane, chains carry between bytes and assembles the result
// plus COUT/OVF/ZERO flags.
module addsub_seq
    import addsub_seq_pkg::*;
#(
    parameter int unsigned NBYTES = 4
) (
    input logic         CLK,
    input logic         RST_N,
    addsub_seq_if.slave bus
);

    localparam int unsigned W  = BYTE_W * NBYTES;
    localparam int unsigned IW = $clog2(NBYTES);
    localparam logic [IW-1:0] LAST_IDX = IW'(NBYTES - 1);

    state_e            state_q;
    logic [IW-1:0]     idx_q;
    logic [W-1:0]      a_q;
    logic [W-1:0]      b_q;
    logic              sub_q;
    logic [W-1:0]      result_q;
    logic              cout_q;
    logic              ovf_q;
    logic              zero_q;
    logic              cisel_q;
    logic              bsel_q;
    logic [BYTE_W-1:0] alu_a_q;
    logic [BYTE_W-1:0] alu_b_q;
    logic              busy_q;
    logic              done_q;

    logic [W-1:0]      result_d;
    logic [IW-1:0]     idx_d;
    logic              last_byte;
    logic              ovf_d;

    // Result with the current ALU byte merged in, next byte index and overflow of the top byte.
    always_comb begin
        result_d = result_q;
        result_d[BYTE_W*idx_q +: BYTE_W] = bus.ALU_S;
        idx_d     = idx_q + 1'b1;
        last_byte = (idx_q == LAST_IDX);
        ovf_d     = (a_q[W-1] ~^ (b_q[W-1] ^ sub_q)) & (a_q[W-1] ^ bus.ALU_S[BYTE_W-1]);
    end

    // Sequencer FSM. ALU-lane drives are registered one byte ahead, so cisel_q
    // doubles as the inter-byte carry register once the first byte has gone out.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q  <= S_IDLE;
            idx_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            sub_q    <= 1'b0;
            result_q <= '0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
            zero_q   <= 1'b0;
            cisel_q  <= 1'b0;
            bsel_q   <= 1'b0;
            alu_a_q  <= '0;
            alu_b_q  <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    done_q <= 1'b0;
                    if (bus.START) begin
                        state_q  <= S_RUN;
                        idx_q    <= '0;
                        a_q      <= bus.A;
                        b_q      <= bus.B;
                        sub_q    <= bus.SUB;
                        result_q <= '0;
                        cout_q   <= 1'b0;
                        ovf_q    <= 1'b0;
                        zero_q   <= 1'b0;
                        cisel_q  <= bus.SUB;
                        bsel_q   <= bus.SUB;
                        alu_a_q  <= bus.A[BYTE_W-1:0];
                        alu_b_q  <= bus.B[BYTE_W-1:0];
                        busy_q   <= 1'b1;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_RUN: begin
                    result_q <= result_d;
                    if (last_byte) begin
                        state_q <= S_DONE;
                        idx_q   <= '0;
                        cout_q  <= bus.ALU_CO;
                        ovf_q   <= ovf_d;
                        zero_q  <= (result_d == '0);
                        cisel_q <= 1'b0;
                        bsel_q  <= 1'b0;
                        alu_a_q <= '0;
                        alu_b_q <= '0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        idx_q   <= idx_d;
                        cisel_q <= bus.ALU_CO;
                        alu_a_q <= a_q[BYTE_W*idx_d +: BYTE_W];
                        alu_b_q <= b_q[BYTE_W*idx_d +: BYTE_W];
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.CISEL  = cisel_q;
    assign bus.BSEL   = bsel_q;
    assign bus.ALU_A  = alu_a_q;
    assign bus.ALU_B  = alu_b_q;
    assign bus.BUSY   = busy_q;
    assign bus.DONE   = done_q;
    assign bus.RESULT = result_q;
    assign bus.COUT   = cout_q;
    assign bus.OVF    = ovf_q;
    assign bus.ZERO   = zero_q;

endmodule
